// File: rtl/input_debounce_pkg.sv
// Shared defaults and types for the input_debounce block.
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN (rise/fall pulse registers).
package input_debounce_pkg;

  localparam int WIDTH_DEF           = 8;
  localparam int CNT_W_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 15;

  // Per-channel stability counter at the default width.
  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, debounced
// level and, when INPUT_DEBOUNCE_EDGE_EN is defined, registered edge pulses.
// o_chg is combinational and high on the cycle whose rising edge flips o_dout.
module debounce_chan
  import input_debounce_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ena,
  input  logic i_din,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall,
  output logic o_chg
);

  // Counter value on the last stable cycle before the level is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_chg;

  // Two-flop synchronizer for the asynchronous pad input; runs regardless of enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
    end
  end

  // The level flips when a differing input has been stable long enough.
  assign w_chg = i_ena && (r_s2 != r_level) && (r_cnt == LAST_CNT);

  // Stability counter and debounced level; both freeze while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_ena) begin
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_chg) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Edge pulses line up with the first cycle the new level is visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_chg & r_s2;
      r_fall <= w_chg & ~r_s2;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

  assign o_dout = r_level;
  assign o_chg  = w_chg;

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input debouncer with a sticky change-event accumulator.
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN enables rise/fall pulses;
// without it rise and fall are constant 0.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_mask,
  input  logic             evt_ack
);

  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] r_evt_mask;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_chan #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_ena   (ena),
      .i_din   (din[gi]),
      .o_dout  (dout[gi]),
      .o_rise  (rise[gi]),
      .o_fall  (fall[gi]),
      .o_chg   (w_chg[gi])
    );
  end

  // Event handshake: evt_valid stays high while evt_mask is non-zero. An
  // edge with evt_valid && evt_ack consumes the pending mask and loads only
  // the changes of that same cycle, so nothing is lost; evt_ack while
  // evt_valid is low has no effect. Without an ack, changes OR in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_mask <= '0;
    end else if (evt_valid && evt_ack) begin
      r_evt_mask <= w_chg;
    end else begin
      r_evt_mask <= r_evt_mask | w_chg;
    end
  end

  assign evt_mask  = r_evt_mask;
  assign evt_valid = |r_evt_mask;

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce with DEBOUNCE_CYCLES=4, WIDTH=8.
// Expected rise/fall depend on whether INPUT_DEBOUNCE_EDGE_EN is defined.
module tb_input_debounce;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int DEB   = 4;
  localparam int SB_W  = 1 + 4 * WIDTH;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             evt_ack;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_valid;

  always #5 clk = ~clk;

  input_debounce #(
    .WIDTH           (WIDTH),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din       (din),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .evt_valid (evt_valid),
    .evt_mask  (evt_mask),
    .evt_ack   (evt_ack)
  );

  // ---------------- scoreboard ----------------
  // Word layout: {evt_valid, evt_mask, fall, rise, dout}
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] obs_w;
  logic [SB_W-1:0] exp_w;
  int checks = 0;
  int errors = 0;

  function automatic logic [SB_W-1:0] observe();
    return {evt_valid, evt_mask, fall, rise, dout};
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic [7:0] r,
                          input logic [7:0] f, input logic [7:0] m);
    logic [7:0] re;
    logic [7:0] fe;
    re = EDGE_EN ? r : 8'h00;
    fe = EDGE_EN ? f : 8'h00;
    exp_q.push_back({(m != 8'h00), m, fe, re, d});
  endtask

  task automatic next_exp(output logic [SB_W-1:0] e);
    if (exp_q.size() == 0) begin
      e = '1;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; evt_ack = 1'b0; din = 8'h00;
    #2;
    push_exp(8'h00, 8'h00, 8'h00, 8'h00);
    next_exp(exp_w); obs_w = observe(); checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL reset_asserted: got %h want %h", obs_w, exp_w);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 2; e++) push_exp(8'h00, 8'h00, 8'h00, 8'h00);
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      next_exp(exp_w); obs_w = observe(); checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL reset_idle edge %0d: got %h want %h", e, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_step();
    din = 8'h01;
    for (int e = 1; e <= 9; e++) begin
      if (e < 6)       push_exp(8'h00, 8'h00, 8'h00, 8'h00);
      else if (e == 6) push_exp(8'h01, 8'h01, 8'h00, 8'h01);
      else if (e < 9)  push_exp(8'h01, 8'h00, 8'h00, 8'h01);
      else             push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    end
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      next_exp(exp_w); obs_w = observe(); checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL step edge %0d: got %h want %h", e, obs_w, exp_w);
      end
      if (e == 8) evt_ack = 1'b1;
      if (e == 9) evt_ack = 1'b0;
    end
  endtask

  task automatic test_glitch();
    din = 8'h05;
    evt_ack = 1'b1;
    for (int e = 1; e <= 10; e++) push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      next_exp(exp_w); obs_w = observe(); checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL glitch edge %0d: got %h want %h", e, obs_w, exp_w);
      end
      if (e == 3) din = 8'h01;
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_ack_same_cycle();
    din = 8'h00;
    push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    push_exp(8'h01, 8'h00, 8'h00, 8'h00);
    push_exp(8'h00, 8'h00, 8'h01, 8'h01);
    push_exp(8'h00, 8'h00, 8'h00, 8'h01);
    push_exp(8'h20, 8'h20, 8'h00, 8'h20);
    push_exp(8'h20, 8'h00, 8'h00, 8'h20);
    push_exp(8'h20, 8'h00, 8'h00, 8'h00);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      next_exp(exp_w); obs_w = observe(); checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL ack_same_cycle edge %0d: got %h want %h", e, obs_w, exp_w);
      end
      if (e == 2) din = 8'h20;
      if (e == 7) evt_ack = 1'b1;
      if (e == 8) evt_ack = 1'b0;
      if (e == 9) evt_ack = 1'b1;
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_enable_freeze();
    din = 8'h28;
    for (int e = 1; e <= 18; e++) begin
      if (e < 16)       push_exp(8'h20, 8'h00, 8'h00, 8'h00);
      else if (e == 16) push_exp(8'h28, 8'h08, 8'h00, 8'h08);
      else if (e == 17) push_exp(8'h28, 8'h00, 8'h00, 8'h08);
      else              push_exp(8'h28, 8'h00, 8'h00, 8'h00);
    end
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk); #1;
      next_exp(exp_w); obs_w = observe(); checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL enable_freeze edge %0d: got %h want %h", e, obs_w, exp_w);
      end
      if (e == 4)  ena = 1'b0;
      if (e == 14) ena = 1'b1;
      if (e == 17) evt_ack = 1'b1;
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    din = 8'hFF;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 8'h00);
    next_exp(exp_w); obs_w = observe(); checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL reset_mid_count: got %h want %h", obs_w, exp_w);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      if (e < 6)       push_exp(8'h00, 8'h00, 8'h00, 8'h00);
      else if (e == 6) push_exp(8'hFF, 8'hFF, 8'h00, 8'hFF);
      else if (e < 9)  push_exp(8'hFF, 8'h00, 8'h00, 8'hFF);
      else             push_exp(8'hFF, 8'h00, 8'h00, 8'h00);
    end
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      next_exp(exp_w); obs_w = observe(); checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL reset_release edge %0d: got %h want %h", e, obs_w, exp_w);
      end
      if (e == 8) evt_ack = 1'b1;
    end
    evt_ack = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_ack_same_cycle();
    test_enable_freeze();
    test_reset_mid_count();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
